// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 keyboard port: transmitter FSM states and completion codes.
// The scan-code receiver imports this package as well.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      SEND,
      ACK,
      WAIT_IDLE
   } ps2_state_e;

   typedef enum logic [1:0] {
      ERR_OK       = 2'd0,
      ERR_NACK     = 2'd1,
      ERR_START_TO = 2'd2,
      ERR_FRAME_TO = 2'd3
   } ps2_err_e;

   localparam int unsigned FRAME_FALLS = 11;
   localparam int unsigned CNT_W       = 20;

   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a run-length filter on one raw PS/2 line.
// The filtered value changes only after FILTER_LEN consecutive differing samples.
module ps2_line_filter #(
   parameter int unsigned FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic line_i,
   output logic line_o
);

   localparam int unsigned RUN_W = $clog2(FILTER_LEN + 1);

   logic [1:0]       sync_q, sync_d;
   logic             filt_q, filt_d;
   logic [RUN_W-1:0] run_q, run_d;

   always_comb begin
      sync_d = {sync_q[0], line_i};
      filt_d = filt_q;
      run_d  = '0;
      if (sync_q[1] != filt_q) begin
         if (run_q == RUN_W'(FILTER_LEN - 1)) begin
            filt_d = sync_q[1];
         end else begin
            run_d = run_q + RUN_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
         filt_q <= 1'b1;
         run_q  <= '0;
      end else begin
         sync_q <= sync_d;
         filt_q <= filt_d;
         run_q  <= run_d;
      end
   end

   assign line_o = filt_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 10 host-driven
// bits clocked by the device, ACK sampling and return-to-idle, with start/frame timeouts.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYC  = 6000,
   parameter int unsigned START_TO_CYC = 750000,
   parameter int unsigned FRAME_TO_CYC = 100000,
   parameter int unsigned FILTER_LEN   = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       busy,
   output logic       done,
   output logic [1:0] err_code,
   input  logic       keyboardCLK,
   input  logic       keyboardData,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYC - 1);
   localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_TO_CYC - 1);
   localparam logic [CNT_W-1:0] FRAME_LAST   = CNT_W'(FRAME_TO_CYC - 1);
   localparam logic [3:0]       STOP_IDX     = 4'(FRAME_FALLS - 2);

   logic fclk, fdata, fclk_prev_q, fall;

   ps2_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [3:0]       bit_q, bit_d;
   logic [8:0]       sr_q, sr_d;
   logic             clk_oe_q, clk_oe_d;
   logic             data_oe_q, data_oe_d;
   logic             done_q, done_d;
   logic             nack_q, nack_d;
   ps2_err_e         err_q, err_d;
   logic             fin;
   ps2_err_e         fin_code;
   logic             start_to, frame_to;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
      .clk    (clk),
      .rst_n  (rst_n),
      .line_i (keyboardCLK),
      .line_o (fclk)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
      .clk    (clk),
      .rst_n  (rst_n),
      .line_i (keyboardData),
      .line_o (fdata)
   );

   assign fall     = fclk_prev_q & ~fclk;
   assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
   assign start_to = (cnt_q >= START_LAST);
   assign frame_to = (cnt_q >= FRAME_LAST);

   assign tx_ready    = (state_q == IDLE) && !done_q;
   assign busy        = ~tx_ready;
   assign done        = done_q;
   assign err_code    = err_q;
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_inc;
      bit_d     = bit_q;
      sr_d      = sr_q;
      clk_oe_d  = clk_oe_q;
      data_oe_d = data_oe_q;
      done_d    = 1'b0;
      err_d     = err_q;
      nack_d    = nack_q;
      fin       = 1'b0;
      fin_code  = ERR_OK;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (tx_valid && tx_ready) begin
               sr_d     = {odd_parity(tx_data), tx_data};
               nack_d   = 1'b0;
               clk_oe_d = 1'b1;
               state_d  = INHIBIT;
            end
         end
         INHIBIT: begin
            if (cnt_q >= INHIBIT_LAST) begin
               data_oe_d = 1'b1;
               state_d   = REQ;
            end
         end
         REQ: begin
            clk_oe_d = 1'b0;
            cnt_d    = '0;
            bit_d    = '0;
            state_d  = SEND;
         end
         SEND: begin
            // Before the first device clock the counter times the start; afterwards the frame.
            if (bit_q == '0 && start_to) begin
               fin      = 1'b1;
               fin_code = ERR_START_TO;
            end else if (bit_q != '0 && frame_to) begin
               fin      = 1'b1;
               fin_code = ERR_FRAME_TO;
            end else if (fall) begin
               bit_d = bit_q + 4'd1;
               if (bit_q == '0) begin
                  cnt_d = '0;
               end
               if (bit_q == STOP_IDX) begin
                  data_oe_d = 1'b0;
                  state_d   = ACK;
               end else begin
                  data_oe_d = ~sr_q[0];
                  sr_d      = {1'b0, sr_q[8:1]};
               end
            end
         end
         ACK: begin
            if (frame_to) begin
               fin      = 1'b1;
               fin_code = ERR_FRAME_TO;
            end else if (fall) begin
               nack_d  = fdata;
               state_d = WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            if (frame_to) begin
               fin      = 1'b1;
               fin_code = ERR_FRAME_TO;
            end else if (fclk && fdata) begin
               fin      = 1'b1;
               fin_code = nack_q ? ERR_NACK : ERR_OK;
            end
         end
         default: state_d = IDLE;
      endcase

      if (fin) begin
         clk_oe_d  = 1'b0;
         data_oe_d = 1'b0;
         done_d    = 1'b1;
         err_d     = fin_code;
         state_d   = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         sr_q        <= '0;
         clk_oe_q    <= 1'b0;
         data_oe_q   <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= ERR_OK;
         nack_q      <= 1'b0;
         fclk_prev_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         sr_q        <= sr_d;
         clk_oe_q    <= clk_oe_d;
         data_oe_q   <= data_oe_d;
         done_q      <= done_d;
         err_q       <= err_d;
         nack_q      <= nack_d;
         fclk_prev_q <= fclk;
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model, behavioural PS/2 device and a
// transaction-level model of handshake/ready/done behaviour checked every cycle.
module tb_ps2_host_tx;

   localparam int unsigned INH  = 100;
   localparam int unsigned STO  = 1000;
   localparam int unsigned FTO  = 2000;
   localparam int unsigned FLEN = 8;
   localparam int unsigned HALF = 40;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready, busy, done;
   logic [1:0] err_code;
   logic       ps2_clk_oe, ps2_data_oe;
   logic       dev_clk_pull = 1'b0;
   logic       dev_data_pull = 1'b0;
   logic       kbd_clk, kbd_data;

   assign kbd_clk  = ~(ps2_clk_oe | dev_clk_pull);
   assign kbd_data = ~(ps2_data_oe | dev_data_pull);

   always #5 clk = ~clk;

   ps2_host_tx #(
      .INHIBIT_CYC  (INH),
      .START_TO_CYC (STO),
      .FRAME_TO_CYC (FTO),
      .FILTER_LEN   (FLEN)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .tx_valid     (tx_valid),
      .tx_data      (tx_data),
      .tx_ready     (tx_ready),
      .busy         (busy),
      .done         (done),
      .err_code     (err_code),
      .keyboardCLK  (kbd_clk),
      .keyboardData (kbd_data),
      .ps2_clk_oe   (ps2_clk_oe),
      .ps2_data_oe  (ps2_data_oe)
   );

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected frame in transmission order: start, 8 data LSB first, odd parity, stop.
   function automatic logic [10:0] model_frame(input logic [7:0] b);
      int          ones;
      logic [10:0] f;
      ones = 0;
      f    = '0;
      for (int i = 0; i < 8; i++) begin
         ones += int'(b[i]);
         f[i+1] = b[i];
      end
      f[0]  = 1'b0;
      f[9]  = ((ones % 2) == 0) ? 1'b1 : 1'b0;
      f[10] = 1'b1;
      return f;
   endfunction

   // ---------------- device model ----------------
   int          dev_mode = 0;   // 0 ack, 1 nack, 2 silent, 3 stop after dev_stop_n clocks
   int          dev_stop_n = 0;
   bit          dev_glitch = 1'b0;
   logic [10:0] dev_bits = '0;
   int          dev_clocks = 0;
   int          dev_frames = 0;

   initial begin : device
      forever begin
         @(negedge clk);
         while (kbd_clk !== 1'b0) @(negedge clk);
         while (!(kbd_clk === 1'b1 && kbd_data === 1'b0)) @(negedge clk);
         if (dev_mode != 2) begin
            dev_clocks = 0;
            dev_bits   = '0;
            repeat (50) @(negedge clk);
            dev_bits[0] = kbd_data;
            for (int k = 1; k <= 10; k++) begin
               if (dev_mode == 3 && dev_clocks == dev_stop_n) break;
               dev_clk_pull = 1'b1;
               repeat (HALF) @(negedge clk);
               dev_clk_pull = 1'b0;
               @(negedge clk);
               dev_bits[k] = kbd_data;
               dev_clocks++;
               if (dev_glitch && k == 4) begin
                  repeat (10) @(negedge clk);
                  dev_clk_pull = 1'b1;
                  repeat (3) @(negedge clk);
                  dev_clk_pull = 1'b0;
                  repeat (HALF - 14) @(negedge clk);
               end else begin
                  repeat (HALF - 1) @(negedge clk);
               end
            end
            if (dev_mode != 3) begin
               dev_data_pull = (dev_mode == 0);
               repeat (20) @(negedge clk);
               dev_clk_pull = 1'b1;
               repeat (HALF) @(negedge clk);
               dev_clk_pull = 1'b0;
               dev_clocks++;
               repeat (HALF) @(negedge clk);
               dev_data_pull = 1'b0;
            end
            dev_frames++;
         end
      end
   end

   // ---------------- transaction model + per-cycle compare ----------------
   logic        exp_ready = 1'b1;
   logic [1:0]  exp_err = 2'd0;
   int unsigned done_cnt = 0;
   int unsigned hs_cnt = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_ready = 1'b1;
      end else begin
         check("tx_ready", tx_ready, exp_ready);
         check("busy", busy, !exp_ready);
         if (exp_ready) begin
            check("idle_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
         end
         if (done) begin
            done_cnt++;
            check("err_code", err_code, exp_err);
            check("done_release", {ps2_clk_oe, ps2_data_oe}, 2'b00);
         end
         if (tx_valid && exp_ready) begin
            exp_ready = 1'b0;
            hs_cnt++;
         end else if (done) begin
            exp_ready = 1'b1;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic handshake(input logic [7:0] b);
      @(posedge clk); #1;
      tx_valid = 1'b1;
      tx_data  = b;
      @(posedge clk); #1;
      tx_valid = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input int mode, input logic [1:0] exp,
                       input int stop_n, input bit glitch, input bit poke, input string tag);
      int unsigned t, d0, h0, f0;
      dev_mode   = mode;
      dev_stop_n = stop_n;
      dev_glitch = glitch;
      exp_err    = exp;
      d0 = done_cnt;
      h0 = hs_cnt;
      f0 = dev_frames;
      handshake(b);
      if (poke) begin
         t = 0;
         while (dev_clocks < 2 && t < 3000) begin @(negedge clk); t++; end
         @(posedge clk); #1;
         tx_valid = 1'b1;
         tx_data  = 8'h55;
         repeat (2) @(posedge clk);
         #1 tx_valid = 1'b0;
      end
      t = 0;
      do begin @(negedge clk); t++; end while (!done && t < 6000);
      check({tag, "_done_seen"}, done, 1'b1);
      repeat (400) @(negedge clk);
      check({tag, "_done_count"}, done_cnt - d0, 1);
      check({tag, "_accepts"}, hs_cnt - h0, 1);
      check({tag, "_ready_after"}, tx_ready, 1'b1);
      if (mode == 0 || mode == 1) begin
         check({tag, "_frame_bits"}, dev_bits, model_frame(b));
         check({tag, "_dev_frames"}, dev_frames - f0, 1);
      end else if (mode == 3) begin
         check({tag, "_dev_clocks"}, dev_clocks, stop_n);
      end
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int unsigned t, inh, req, d0;

      #1;
      check("rst_tx_ready", tx_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err_code, 2'd0);
      check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(posedge clk);

      check("model_frame_ED", model_frame(8'hED), 11'h7DA);
      check("model_frame_01", model_frame(8'h01), 11'h402);
      check("model_frame_00", model_frame(8'h00), 11'h600);

      send(8'hED, 0, 2'd0, 0, 1'b0, 1'b0, "ack_ED");
      check("ED_bits_literal", dev_bits, 11'h7DA);
      send(8'h01, 0, 2'd0, 0, 1'b0, 1'b0, "ack_01");
      send(8'h00, 0, 2'd0, 0, 1'b0, 1'b0, "ack_00");
      send(8'hFF, 1, 2'd1, 0, 1'b0, 1'b0, "nack_FF");

      // Silent device: inhibit length, single request cycle, exact start timeout.
      dev_mode = 2;
      exp_err  = 2'd2;
      handshake(8'hF4);
      inh = 0;
      req = 0;
      t   = 0;
      do begin
         @(negedge clk);
         t++;
         if (ps2_clk_oe && !ps2_data_oe) inh++;
         if (ps2_clk_oe && ps2_data_oe) req++;
      end while (!(!ps2_clk_oe && ps2_data_oe) && t < 500);
      check("inhibit_cycles", inh, INH);
      check("req_cycles", req, 1);
      t = 0;
      do begin @(negedge clk); t++; end while (!done && t < 3000);
      check("start_to_latency", t, STO);
      repeat (20) @(negedge clk);

      send(8'hA5, 3, 2'd3, 5, 1'b0, 1'b0, "frame_to");

      // Clock glitch must not advance the bit counter; tx_valid while busy is ignored.
      send(8'h3C, 0, 2'd0, 0, 1'b1, 1'b1, "glitch_poke");
      dev_glitch = 1'b0;

      // Asynchronous reset in the middle of a frame.
      dev_mode   = 3;
      dev_stop_n = 4;
      dev_clocks = 0;
      handshake(8'h96);
      t = 0;
      while (dev_clocks < 4 && t < 3000) begin @(negedge clk); t++; end
      check("midframe_busy", busy, 1'b1);
      d0 = done_cnt;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("rst_mid_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
      check("rst_mid_ready", tx_ready, 1'b1);
      check("rst_mid_done", done, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (200) @(negedge clk);
      check("rst_mid_no_done", done_cnt - d0, 0);

      send(8'hF4, 0, 2'd0, 0, 1'b0, 1'b0, "ack_F4");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
